quaternary_merge_scheduler: RTL
===============================

# quaternary_merge_scheduler

- Sequences one 4-way merge of sorted coordinate fibers: it pulls beats from four input lanes and emits them as a single ascending stream, tagging each beat with its source lane.
- It contains the min-selection logic and a one-entry registered output stage.
- It tracks per-lane end-of-fiber and signals completion of each merge round.
- It sits between the per-fiber input FIFOs and the downstream merger/accumulator stage of the SpGEMM merge tree.

## Interface

Parameters:
- COORD_W, default 64: coordinate width.
- CNT_W, default 16: width of the output beat counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a merge round; only sampled in IDLE.
- lane_mask  in  4  lanes participating in the round; latched on an accepted start.
- lane_coord  in  4*COORD_W  packed lane coordinates; lane i is at [i*COORD_W +: COORD_W].
- lane_valid  in  4  per-lane beat valid.
- lane_last  in  4  per-lane beat is the final beat of its fiber.
- lane_ready  out  4  per-lane pop, combinational, one-hot or zero.
- out_coord  out  COORD_W  merged coordinate, registered.
- out_lane  out  2  source lane of out_coord.
- out_valid  out  1  out_coord is valid.
- out_last  out  1  final beat of the round.
- out_ready  in  1  downstream accepts the output beat.
- busy  out  1  high in MERGE or DONE.
- done  out  1  one-cycle pulse when the round completes.
- beat_count  out  CNT_W  beats emitted this round; wraps modulo 2^CNT_W.

## Operation

- The state machine has three states: IDLE, MERGE and DONE.
- IDLE:
  - On start, latch active = lane_mask and clear beat_count.
  - If lane_mask != 0, go to MERGE.
  - If lane_mask == 0, go to DONE and emit no beats.
- MERGE:
  - A lane is live while its active bit is set.
  - A pick is eligible when every live lane has lane_valid=1 and the output slot is free.
  - The output slot is free when out_valid=0, or when out_valid && out_ready.
  - Valid bits of non-live lanes are ignored.
  - The pick is the live lane with the minimum lane_coord, compared unsigned.
  - Ties go to the lowest lane index. Equal coordinates are emitted as separate beats; no coalescing.
  - On a pick, lane_ready[pick]=1 in the same cycle.
  - At the next edge: out_coord/out_lane are loaded, out_valid=1, and beat_count increments.
  - If lane_last[pick]=1, active[pick] is cleared.
  - out_last=1 when the picked beat clears the last remaining active bit.
  - When the out_last beat is handshaked, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Output hold: while out_valid && !out_ready, out_coord, out_lane and out_last stay stable and lane_ready=0.
- out_valid deasserts on a handshake with no new pick.
- start is ignored when not in IDLE.
- lane_valid asserted on a non-live lane is never popped.
- Reset, asynchronous, active-low, including mid-round:
  - state returns to IDLE and active=0.
  - out_valid=0, out_last=0, out_coord=0, out_lane=0.
  - beat_count=0, busy=0, done=0, lane_ready=0.
  - In-flight beats are discarded.

## Timing

- Pick-to-output latency is 1 cycle: a pop at edge N makes out_valid high after edge N.
- Back-to-back beats: sustained throughput is 1 beat/cycle when all live lanes stay valid and out_ready=1.
- A stall on any live lane's lane_valid stalls all picks. lane_ready stays 0 until that lane is valid.
- start (IDLE) to first possible lane_ready: 1 cycle (the first MERGE cycle).
- out_last handshake at edge N:
  - DONE during cycle N+1, with done=1.
  - IDLE from N+2.
  - A start at N+2 is accepted.
- lane_mask==0: start at edge N gives done=1 in cycle N+1 and beat_count=0.
- busy is a registered function of state only.

## Test plan

- Basic merge:
  - Stimulus: mask=1111, one beat per lane, coords 3,2,4,1 (all last), out_ready=1.
  - Required: outputs 1,2,3,4 with lanes 3,1,0,2 on consecutive cycles; out_last on the 4th beat; done one cycle later; beat_count=4.
- Ties and multi-beat fibers:
  - Stimulus: lane0={1,3}, lane1={3}, lane2={3,5}, lane3={5}.
  - Required: coords 1,3,3,3,5,5 from lanes 0,0,1,2,2,3.
- Mask and ignored lanes:
  - Stimulus: mask=0101, lane1/lane3 held valid with coord 0.
  - Required: lanes 1 and 3 are never popped, and only lane0/lane2 beats are emitted.
  - Stimulus: mask=0000.
  - Required: done pulse, no out_valid.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles mid-stream.
  - Required: out_coord/out_lane held stable and lane_ready=0 throughout; no beat lost or duplicated after release.
- Lane stall:
  - Stimulus: live lane2 drops lane_valid for 3 cycles.
  - Required: no pops during the stall, order preserved afterwards.
- Reset mid-round:
  - Stimulus: assert reset asynchronously (between clock edges) after 2 beats.
  - Required: all outputs 0 immediately; a new start then runs a fresh round with beat_count from 0.

Source files
------------

// File: rtl/quaternary_merge_scheduler.sv
// Four-lane sorted-fiber merger: picks the live lane with the smallest coordinate
// each cycle and emits it through a one-entry registered output stage.
module quaternary_merge_scheduler #(
    parameter int COORD_W = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           lane_mask,
    input  logic [4*COORD_W-1:0] lane_coord,
    input  logic [3:0]           lane_valid,
    input  logic [3:0]           lane_last,
    output logic [3:0]           lane_ready,
    output logic [COORD_W-1:0]   out_coord,
    output logic [1:0]           out_lane,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     beat_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MERGE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [3:0]         active_r;
    logic [3:0]         active_nxt_s;
    logic [COORD_W-1:0] out_coord_r;
    logic [1:0]         out_lane_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   beat_count_r;
    logic               all_valid_s;
    logic               slot_free_s;
    logic               pick_en_s;
    logic [1:0]         pick_lane_s;
    logic [3:0]         pick_oh_s;
    logic [3:0]         clear_s;

    // Lowest-index lane holding the unsigned minimum among the live lanes.
    function automatic logic [1:0] min_lane(input logic [3:0] live,
                                            input logic [4*COORD_W-1:0] coords);
        logic [COORD_W-1:0] best;
        logic               found;
        logic [1:0]         idx;
        best  = {COORD_W{1'b0}};
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (live[i] && (!found || (coords[i*COORD_W +: COORD_W] < best))) begin
                best  = coords[i*COORD_W +: COORD_W];
                found = 1'b1;
                idx   = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Pick eligibility, lane pop and active-set update; non-live lanes never block a pick.
    always_comb begin
        all_valid_s  = &(lane_valid | ~active_r);
        slot_free_s  = !out_valid_r || out_ready;
        pick_lane_s  = min_lane(active_r, lane_coord);
        pick_oh_s    = 4'b0001 << pick_lane_s;
        pick_en_s    = (state_r == ST_MERGE) && (|active_r) && all_valid_s && slot_free_s;
        lane_ready   = 4'b0000;
        clear_s      = 4'b0000;
        if (pick_en_s) begin
            lane_ready = pick_oh_s;
            clear_s    = pick_oh_s & lane_last;
        end else begin
            lane_ready = 4'b0000;
        end
        active_nxt_s = active_r & ~clear_s;
    end

    // Round sequencing: leave MERGE only once the final beat has been accepted downstream.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (lane_mask != 4'b0000) ? ST_MERGE : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MERGE: begin
                if (out_valid_r && out_ready && out_last_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MERGE;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, active set, status flags and beat counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            active_r     <= 4'b0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            beat_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_MERGE) || (state_nxt_s == ST_DONE);
            done_r  <= (state_nxt_s == ST_DONE);
            if ((state_r == ST_IDLE) && start) begin
                active_r     <= lane_mask;
                beat_count_r <= {CNT_W{1'b0}};
            end else if (pick_en_s) begin
                active_r     <= active_nxt_s;
                beat_count_r <= beat_count_r + CNT_W'(1);
            end else begin
                active_r     <= active_r;
                beat_count_r <= beat_count_r;
            end
        end
    end

    // One-entry output slot: reload on a pick, drain on a handshake, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_coord_r <= {COORD_W{1'b0}};
            out_lane_r  <= 2'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (pick_en_s) begin
            out_coord_r <= lane_coord[pick_lane_s*COORD_W +: COORD_W];
            out_lane_r  <= pick_lane_s;
            out_valid_r <= 1'b1;
            out_last_r  <= (active_nxt_s == 4'b0000);
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    assign out_coord  = out_coord_r;
    assign out_lane   = out_lane_r;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign beat_count = beat_count_r;

endmodule
